data_mem_ctrl: RTL and testbench

//   Parametrised byte-addressable data memory for the MEM stage: byte/half/word loads and stores,

---
 rtl/mem_pkg.sv | 28 ++
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/data_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, controller states
// and the alignment rule used at request acceptance.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_X = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Illegal size is folded in here so the top only adds the range check.
  function automatic logic mem_bad_align(input logic [1:0] size, input logic [1:0] lo);
    case (mem_size_e'(size))
      MEM_B:   return 1'b0;
      MEM_H:   return lo[0];
      MEM_W:   return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response channel between the MEM stage (master) and the data memory (slave).
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store byte enables/replicated data and
// load lane select with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign bsel = rword[{lo, 3'b000} +: 8];
  assign hsel = lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    rdata = '0;
    case (mem_size_e'(size))
      MEM_B: begin
        be    = 4'b0001 << lo;
        wword = {4{wdata[7:0]}};
        rdata = uns ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
      end
      MEM_H: begin
        be    = lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = uns ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
      end
      MEM_W: begin
        be    = 4'b1111;
        rdata = rword;
      end
      default: begin
        be    = 4'b0000;
        rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with a single outstanding request, programmable
// wait states, and registered load/error response.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  mem_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        src_we;
  logic        src_uns;
  logic [1:0]  src_size;
  logic [31:0] src_addr;
  logic [31:0] src_wdata;
  logic        src_err;
  logic        accept;
  logic        fire;
  logic [AW-1:0] base;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] load_data;

  // With no wait states the access happens on the accepting edge, so the live
  // request fields are used; otherwise the latched copy is.
  always_comb begin
    src_we    = we_q;
    src_uns   = uns_q;
    src_size  = size_q;
    src_addr  = addr_q;
    src_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      src_we    = bus.req_we;
      src_uns   = bus.req_unsigned;
      src_size  = bus.req_size;
      src_addr  = bus.req_addr;
      src_wdata = bus.req_wdata;
    end
  end

  assign src_err = mem_bad_align(src_size, src_addr[1:0]) || (src_addr >= 32'(DEPTH_BYTES));
  assign accept  = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;
  assign fire    = (WAIT_STATES == 0) ? accept : ((state_q == ST_WAIT) && (cnt_q == LAST));
  assign base    = src_addr[AW-1:0] & ~AW'(3);
  assign rword   = {mem[base | AW'(3)], mem[base | AW'(2)], mem[base | AW'(1)], mem[base]};

  mem_lane_align u_align (
    .size  (src_size),
    .uns   (src_uns),
    .lo    (src_addr[1:0]),
    .wdata (src_wdata),
    .rword (rword),
    .be    (be),
    .wword (wword),
    .rdata (load_data)
  );

  always_ff @(posedge clk) begin
    if (fire && src_we && !src_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[base | AW'(i)] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == LAST) state_q <= ST_RESP;
          else               cnt_q   <= cnt_q + 4'd1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (fire) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= src_err;
        rsp_rdata_q <= (src_err || src_we) ? 32'h0 : load_data;
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance with no wait states, one with three,
// driven through a shared request bus steered by sel.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  data_mem_ctrl_if if0 ();
  data_mem_ctrl_if if3 ();

  data_mem_ctrl #(.DEPTH_BYTES(256), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  data_mem_ctrl #(.DEPTH_BYTES(256), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  assign if0.req_valid    = req_valid & ~sel;
  assign if3.req_valid    = req_valid & sel;
  assign if0.rsp_ready    = rsp_ready & ~sel;
  assign if3.rsp_ready    = rsp_ready & sel;
  assign if0.req_we       = req_we;
  assign if3.req_we       = req_we;
  assign if0.req_size     = req_size;
  assign if3.req_size     = req_size;
  assign if0.req_unsigned = req_unsigned;
  assign if3.req_unsigned = req_unsigned;
  assign if0.req_addr     = req_addr;
  assign if3.req_addr     = req_addr;
  assign if0.req_wdata    = req_wdata;
  assign if3.req_wdata    = req_wdata;

  assign req_ready_m = sel ? if3.req_ready : if0.req_ready;
  assign rsp_valid_m = sel ? if3.rsp_valid : if0.rsp_valid;
  assign rsp_err_m   = sel ? if3.rsp_err   : if0.rsp_err;
  assign rsp_rdata_m = sel ? if3.rsp_rdata : if0.rsp_rdata;

  int n_vec;
  int n_bad;

  logic [7:0] model_mem [256];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: an access of 2**size bytes, little-endian, aligned and in range.
  function automatic void model_op(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output logic [31:0] rd, output logic err);
    int n;
    logic [63:0] v;
    n   = 1 << size;
    rd  = 32'h0;
    err = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'd256);
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) model_mem[addr[7:0] + 8'(i)] = wdata[8*i +: 8];
    end else begin
      v = 64'h0;
      for (int i = 0; i < n; i++) v = v | (64'(model_mem[addr[7:0] + 8'(i)]) << (8*i));
      if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  task automatic accept_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int g;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready_m && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready_seen", {31'h0, req_ready_m}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
  endtask

  task automatic wait_rsp();
    int lat;
    int g;
    lat = 1;
    g = 0;
    while (!rsp_valid_m && g < 50) begin
      @(posedge clk);
      #1;
      lat++;
      g++;
    end
    chk("latency", lat, sel ? 32'd4 : 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic err);
    accept_req(we, size, uns, addr, wdata);
    wait_rsp();
    rd  = rsp_rdata_m;
    err = rsp_err_m;
    handshake();
  endtask

  logic [31:0] rd, erd;
  logic        err, eerr;

  initial begin
    n_vec = 0; n_bad = 0;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h8badf00d, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h8badf00d, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hffffff8b, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h0000008b, 1'b0};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hffff8bad, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'h00008bad, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'h11,  32'hffffff5a, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h8bad5a0d, 1'b0};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        32'h00005a0d, 1'b0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        32'h00000000, 1'b1};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h11,  32'h00001234, 32'h00000000, 1'b1};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h00000000, 1'b1};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h110, 32'hdeadbeef, 32'h00000000, 1'b1};
    tbl[14] = '{1'b1, 2'd3, 1'b0, 32'h10,  32'hcafecafe, 32'h00000000, 1'b1};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h8bad5a0d, 1'b0};

    sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready0", {31'h0, if0.req_ready}, 32'h0);
    chk("rst_rsp_valid0", {31'h0, if0.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata0", if0.rsp_rdata, 32'h0);
    chk("rst_rsp_err0",   {31'h0, if0.rsp_err}, 32'h0);
    chk("rst_req_ready3", {31'h0, if3.req_ready}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_req_ready0", {31'h0, if0.req_ready}, 32'h1);
    chk("rel_req_ready3", {31'h0, if3.req_ready}, 32'h1);

    // Give the region used by the random phase known contents.
    for (int a = 0; a < 64; a += 4) begin
      logic [31:0] w;
      w = $urandom;
      model_op(1'b1, 2'd2, 1'b0, 32'(a), w, erd, eerr);
      txn(1'b1, 2'd2, 1'b0, 32'(a), w, rd, err);
      chk("init_err", {31'h0, err}, {31'h0, eerr});
    end

    for (int i = 0; i < 16; i++) begin
      model_op(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, erd, eerr);
      txn(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, err);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
    end

    for (int k = 0; k < 150; k++) begin
      logic we, uns;
      logic [1:0] size;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(200, 400)) : 32'($urandom_range(0, 63));
      wdata = $urandom;
      model_op(we, size, uns, addr, wdata, erd, eerr);
      txn(we, size, uns, addr, wdata, rd, err);
      chk("rand_rdata", rd, erd);
      chk("rand_err", {31'h0, err}, {31'h0, eerr});
    end

    // Three wait states, response held back by the consumer.
    sel = 1'b1;
    txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, err);
    chk("ws_store_err", {31'h0, err}, 32'h0);
    accept_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    chk("ws_ready_low_wait", {31'h0, req_ready_m}, 32'h0);
    wait_rsp();
    for (int c = 0; c < 4; c++) begin
      chk("ws_hold_valid", {31'h0, rsp_valid_m}, 32'h1);
      chk("ws_hold_rdata", rsp_rdata_m, 32'h11223344);
      chk("ws_hold_ready", {31'h0, req_ready_m}, 32'h0);
      @(posedge clk);
      #1;
    end
    handshake();
    chk("ws_valid_drop", {31'h0, rsp_valid_m}, 32'h0);
    chk("ws_ready_back", {31'h0, req_ready_m}, 32'h1);

    // Reset during the wait of a store: the write must be lost.
    txn(1'b1, 2'd2, 1'b0, 32'h24, 32'haaaaaaaa, rd, err);
    accept_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h55555555);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, rsp_valid_m}, 32'h0);
    chk("mid_rst_ready", {31'h0, req_ready_m}, 32'h0);
    chk("mid_rst_rdata", rsp_rdata_m, 32'h0);
    chk("mid_rst_err", {31'h0, rsp_err_m}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", {31'h0, req_ready_m}, 32'h1);
    txn(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, err);
    chk("lost_write", rd, 32'haaaaaaaa);

    // Reset after the write already happened: the write must stay.
    accept_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h13579bdf);
    wait_rsp();
    rst_n = 1'b0;
    #1;
    chk("late_rst_valid", {31'h0, rsp_valid_m}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, err);
    chk("kept_write", rd, 32'h13579bdf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
